// File: rtl/mem_arbiter_pkg.sv
// Shared constants and type encodings for the I/D memory-port arbiter.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS      = 128;
  localparam int CPU_WORD_ADDR_BITS = 30;
  // A memory block holds MEM_DATA_BITS/32 CPU words, so those low word-address bits drop out.
  localparam int MEM_ADDR_BITS      = CPU_WORD_ADDR_BITS - $clog2(MEM_DATA_BITS / 32);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Beat counter width; at least one bit so single-beat configurations still elaborate.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input picker: round-robin on ties, or D-first when FIXED_PRIORITY is set.
module mem_arb_rr
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic   icache_valid,
  input  logic   dcache_valid,
  input  owner_t last_owner,
  output logic   any_valid,
  output owner_t winner
);

  assign any_valid = icache_valid | dcache_valid;

  // Lone requester wins; on a tie either D wins outright or the cache not served last wins.
  always_comb begin
    winner = OWN_D;
    if (icache_valid && !dcache_valid) begin
      winner = OWN_I;
    end else if (icache_valid && dcache_valid) begin
      if (FIXED_PRIORITY != 0) begin
        winner = OWN_D;
      end else begin
        winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between the instruction and data caches,
// one transaction at a time, steering read beats back to the granted cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS      = MEM_ADDR_BITS,
  parameter int DATA_BITS      = MEM_DATA_BITS,
  parameter int READ_BEATS     = 4,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  // instruction cache
  input  logic                   i_mem_req_valid,
  output logic                   i_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   i_mem_req_addr,
  input  logic                   i_mem_req_rw,
  input  logic                   i_mem_req_data_valid,
  output logic                   i_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   i_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] i_mem_req_data_mask,
  output logic                   i_mem_resp_valid,
  output logic [DATA_BITS-1:0]   i_mem_resp_data,
  // data cache
  input  logic                   d_mem_req_valid,
  output logic                   d_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   d_mem_req_addr,
  input  logic                   d_mem_req_rw,
  input  logic                   d_mem_req_data_valid,
  output logic                   d_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   d_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] d_mem_req_data_mask,
  output logic                   d_mem_resp_valid,
  output logic [DATA_BITS-1:0]   d_mem_resp_data,
  // downstream memory
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   spurious_resp
);

  localparam int              CNT_W     = cnt_width(READ_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

  arb_state_t       state, state_n;
  owner_t           owner, owner_n;
  owner_t           last_owner, last_owner_n;
  logic             owner_rw, owner_rw_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic             req_done, req_done_n;
  logic             data_done, data_done_n;
  logic             spurious_n;

  owner_t pick;
  logic   pick_any;

  mem_arb_rr #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .icache_valid(i_mem_req_valid),
    .dcache_valid(d_mem_req_valid),
    .last_owner  (last_owner),
    .any_valid   (pick_any),
    .winner      (pick)
  );

  // Owner-side view of the request channel.
  logic                   own_req_valid;
  logic                   own_data_valid;
  logic                   own_is_d;
  assign own_is_d       = (owner == OWN_D);
  assign own_req_valid  = own_is_d ? d_mem_req_valid      : i_mem_req_valid;
  assign own_data_valid = own_is_d ? d_mem_req_data_valid : i_mem_req_data_valid;

  // rw is latched at grant so the write-data phase survives the cache dropping its request.
  assign mem_req_addr      = own_is_d ? d_mem_req_addr      : i_mem_req_addr;
  assign mem_req_rw        = owner_rw;
  assign mem_req_data_bits = own_is_d ? d_mem_req_data_bits : i_mem_req_data_bits;
  assign mem_req_data_mask = own_is_d ? d_mem_req_data_mask : i_mem_req_data_mask;

  // Everything visible is gated by reset so a mid-transaction reset looks idle at once.
  logic in_grant, in_resp;
  assign in_grant = ~reset & (state == ST_GRANT);
  assign in_resp  = ~reset & (state == ST_RESP);

  logic own_req_ready, own_data_ready, own_resp_valid;
  assign mem_req_valid      = in_grant & own_req_valid & ~req_done;
  assign mem_req_data_valid = in_grant & owner_rw & own_data_valid & ~data_done;
  assign own_req_ready      = in_grant & mem_req_ready & ~req_done;
  assign own_data_ready     = in_grant & owner_rw & mem_req_data_ready & ~data_done;
  assign own_resp_valid     = in_resp & mem_resp_valid;

  assign i_mem_req_ready      = ~own_is_d & own_req_ready;
  assign d_mem_req_ready      =  own_is_d & own_req_ready;
  assign i_mem_req_data_ready = ~own_is_d & own_data_ready;
  assign d_mem_req_data_ready =  own_is_d & own_data_ready;
  assign i_mem_resp_valid     = ~own_is_d & own_resp_valid;
  assign d_mem_resp_valid     =  own_is_d & own_resp_valid;
  assign i_mem_resp_data      = mem_resp_data;
  assign d_mem_resp_data      = mem_resp_data;

  logic req_fire, data_fire;
  assign req_fire  = mem_req_valid & mem_req_ready;
  assign data_fire = mem_req_data_valid & mem_req_data_ready;

  // Next-state: arbitrate in IDLE, track write handshakes in GRANT, count read beats in RESP.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    owner_rw_n   = owner_rw;
    beat_cnt_n   = beat_cnt;
    req_done_n   = req_done;
    data_done_n  = data_done;
    spurious_n   = spurious_resp | (mem_resp_valid & (state != ST_RESP));
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n    = ST_GRANT;
          owner_n    = pick;
          owner_rw_n = (pick == OWN_D) ? d_mem_req_rw : i_mem_req_rw;
        end
      end
      ST_GRANT: begin
        if (!owner_rw) begin
          if (req_fire) begin
            state_n    = ST_RESP;
            beat_cnt_n = '0;
          end
        end else begin
          req_done_n  = req_done | req_fire;
          data_done_n = data_done | data_fire;
          if (req_done_n && data_done_n) begin
            state_n      = ST_IDLE;
            last_owner_n = owner;
            req_done_n   = 1'b0;
            data_done_n  = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) begin
            state_n      = ST_IDLE;
            last_owner_n = owner;
            beat_cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= OWN_I;
      last_owner    <= OWN_I;
      owner_rw      <= 1'b0;
      beat_cnt      <= '0;
      req_done      <= 1'b0;
      data_done     <= 1'b0;
      spurious_resp <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      last_owner    <= last_owner_n;
      owner_rw      <= owner_rw_n;
      beat_cnt      <= beat_cnt_n;
      req_done      <= req_done_n;
      data_done     <= data_done_n;
      spurious_resp <= spurious_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = MEM_ADDR_BITS;
  localparam int DW = MEM_DATA_BITS;
  localparam int MW = DW / 8;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // cache-side stimulus, index 0 = I, 1 = D
  logic          c_valid  [2];
  logic          c_rw     [2];
  logic [AW-1:0] c_addr   [2];
  logic          c_dvalid [2];
  logic [DW-1:0] c_data   [2];
  logic [MW-1:0] c_mask   [2];

  logic          mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [DW-1:0] mem_resp_data;

  // round-robin instance outputs
  logic          i_req_ready, i_data_ready, i_resp_valid, d_req_ready, d_data_ready, d_resp_valid;
  logic [DW-1:0] i_resp_data, d_resp_data;
  logic          mem_req_valid, mem_req_rw, mem_req_data_valid, spurious_resp;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;

  // fixed-priority instance outputs
  logic          fp_i_req_ready, fp_i_data_ready, fp_i_resp_valid, fp_d_req_ready, fp_d_data_ready, fp_d_resp_valid;
  logic [DW-1:0] fp_i_resp_data, fp_d_resp_data;
  logic          fp_mem_req_valid, fp_mem_req_rw, fp_mem_req_data_valid, fp_spurious;
  logic [AW-1:0] fp_mem_req_addr;
  logic [DW-1:0] fp_mem_req_data_bits;
  logic [MW-1:0] fp_mem_req_data_mask;

  logic [1:0] rdy_v, drdy_v, rsp_v;
  assign rdy_v  = {d_req_ready, i_req_ready};
  assign drdy_v = {d_data_ready, i_data_ready};
  assign rsp_v  = {d_resp_valid, i_resp_valid};

  mem_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .i_mem_req_valid(c_valid[0]), .i_mem_req_ready(i_req_ready), .i_mem_req_addr(c_addr[0]),
    .i_mem_req_rw(c_rw[0]), .i_mem_req_data_valid(c_dvalid[0]), .i_mem_req_data_ready(i_data_ready),
    .i_mem_req_data_bits(c_data[0]), .i_mem_req_data_mask(c_mask[0]),
    .i_mem_resp_valid(i_resp_valid), .i_mem_resp_data(i_resp_data),
    .d_mem_req_valid(c_valid[1]), .d_mem_req_ready(d_req_ready), .d_mem_req_addr(c_addr[1]),
    .d_mem_req_rw(c_rw[1]), .d_mem_req_data_valid(c_dvalid[1]), .d_mem_req_data_ready(d_data_ready),
    .d_mem_req_data_bits(c_data[1]), .d_mem_req_data_mask(c_mask[1]),
    .d_mem_resp_valid(d_resp_valid), .d_mem_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .spurious_resp(spurious_resp)
  );

  mem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .i_mem_req_valid(c_valid[0]), .i_mem_req_ready(fp_i_req_ready), .i_mem_req_addr(c_addr[0]),
    .i_mem_req_rw(c_rw[0]), .i_mem_req_data_valid(c_dvalid[0]), .i_mem_req_data_ready(fp_i_data_ready),
    .i_mem_req_data_bits(c_data[0]), .i_mem_req_data_mask(c_mask[0]),
    .i_mem_resp_valid(fp_i_resp_valid), .i_mem_resp_data(fp_i_resp_data),
    .d_mem_req_valid(c_valid[1]), .d_mem_req_ready(fp_d_req_ready), .d_mem_req_addr(c_addr[1]),
    .d_mem_req_rw(c_rw[1]), .d_mem_req_data_valid(c_dvalid[1]), .d_mem_req_data_ready(fp_d_data_ready),
    .d_mem_req_data_bits(c_data[1]), .d_mem_req_data_mask(c_mask[1]),
    .d_mem_resp_valid(fp_d_resp_valid), .d_mem_resp_data(fp_d_resp_data),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(fp_mem_req_addr),
    .mem_req_rw(fp_mem_req_rw), .mem_req_data_valid(fp_mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(fp_mem_req_data_bits), .mem_req_data_mask(fp_mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .spurious_resp(fp_spurious)
  );

  int checks   = 0;
  int failures = 0;
  bit last_model;  // cache that most recently completed a transaction (0 = I, 1 = D)

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input bit who);
    return who ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_caches();
    for (int k = 0; k < 2; k++) begin
      c_valid[k] = 1'b0; c_rw[k] = 1'b0; c_addr[k] = '0;
      c_dvalid[k] = 1'b0; c_data[k] = '0; c_mask[k] = '0;
    end
  endtask

  task automatic setup_req(input bit who, input bit rw, input logic [AW-1:0] addr);
    c_valid[who]  = 1'b1;
    c_rw[who]     = rw;
    c_addr[who]   = addr;
    c_dvalid[who] = rw;
    c_data[who]   = rnd_data();
    c_mask[who]   = MW'($urandom);
  endtask

  // Plays the memory side for one transaction owned by 'who'. Entered at the start of
  // the cycle in which the arbiter is idle with the request visible; returns at the start
  // of the first cycle after completion.
  task automatic serve(input bit who, input int rdly, input int ddly, input bit fixed_beats);
    bit rq_seen, dt_seen, rq_now, dt_now, rw;
    logic [DW-1:0] beat;
    rq_seen = 1'b0; dt_seen = 1'b0; rw = c_rw[who];
    #1;
    chk("arb_latency", mem_req_valid, 0);
    chk("idle_ready", rdy_v, 0);
    tick();
    for (int c = 0; c < 8 && !(rq_seen && (dt_seen || !rw)); c++) begin
      mem_req_ready      = (c >= rdly);
      mem_req_data_ready = (c >= ddly);
      #1;
      chk("req_valid", mem_req_valid, !rq_seen);
      if (!rq_seen) begin
        chk("req_addr", mem_req_addr, c_addr[who]);
        chk("req_rw", mem_req_rw, rw);
      end
      rq_now = !rq_seen && mem_req_ready;
      dt_now = rw && !dt_seen && mem_req_data_ready;
      chk("req_ready", rdy_v, rq_now ? onehot(who) : 2'b00);
      chk("data_valid", mem_req_data_valid, rw && !dt_seen);
      if (rw && !dt_seen) begin
        chk("data_bits", mem_req_data_bits, c_data[who]);
        chk("data_mask", mem_req_data_mask, c_mask[who]);
      end
      chk("data_ready", drdy_v, dt_now ? onehot(who) : 2'b00);
      chk("grant_no_resp", rsp_v, 0);
      tick();
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      if (rq_now) begin rq_seen = 1'b1; c_valid[who] = 1'b0; end
      if (dt_now) begin dt_seen = 1'b1; c_dvalid[who] = 1'b0; end
    end
    chk("grant_done", rq_seen && (dt_seen || !rw), 1);
    if (!rw) begin
      for (int b = 0; b < NB; b++) begin
        repeat ($urandom_range(0, 2)) begin
          #1;
          chk("resp_gap", rsp_v, 0);
          chk("resp_no_fwd", mem_req_valid, 0);
          chk("resp_no_ready", rdy_v, 0);
          tick();
        end
        beat = fixed_beats ? DW'(8'hA0 + b) : rnd_data();
        mem_resp_valid = 1'b1; mem_resp_data = beat;
        #1;
        chk("resp_route", rsp_v, onehot(who));
        chk("i_resp_data", i_resp_data, beat);
        chk("d_resp_data", d_resp_data, beat);
        tick();
        mem_resp_valid = 1'b0;
      end
    end
  endtask

  initial begin
    bit w;
    int mode;
    logic [AW-1:0] a;
    reset = 1'b1;
    clear_caches();
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_data_valid", mem_req_data_valid, 0);
    chk("rst_ready", rdy_v, 0);
    chk("rst_data_ready", drdy_v, 0);
    chk("rst_resp", rsp_v, 0);
    chk("rst_spurious", spurious_resp, 0);
    tick();

    // I read alone, beats A0..A3 routed to I only
    setup_req(1'b0, 1'b0, AW'(28'h0000010));
    serve(1'b0, 0, 0, 1'b1);

    // D write, request accepted at t, data at t+2
    setup_req(1'b1, 1'b1, AW'(28'h0000200));
    serve(1'b1, 0, 2, 1'b0);
    #1;
    chk("write_idle_valid", mem_req_valid, 0);
    chk("write_no_resp", rsp_v, 0);
    tick();

    // simultaneous I read and D write from reset: D first, then owners alternate
    reset = 1'b1; tick(); reset = 1'b0;
    last_model = 1'b0;
    for (int r = 0; r < 3; r++) begin
      a = AW'($urandom);
      setup_req(1'b0, 1'b0, a);
      setup_req(1'b1, 1'b1, a ^ AW'(1));
      w = last_model ? 1'b0 : 1'b1;
      serve(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      serve(!w, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      last_model = !w;
    end

    // spurious beat in IDLE: dropped, sticky flag until reset
    mem_resp_valid = 1'b1; mem_resp_data = rnd_data();
    #1;
    chk("spur_no_route", rsp_v, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("spur_set", spurious_resp, 1);
    tick(); tick(); tick();
    chk("spur_sticky", spurious_resp, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("spur_cleared", spurious_resp, 0);
    tick();

    // reset after beat 2 of a D read, then an I read completes normally
    setup_req(1'b1, 1'b0, AW'(28'h0ABCDE0));
    tick();
    mem_req_ready = 1'b1;
    #1;
    chk("mid_req_valid", mem_req_valid, 1);
    tick();
    mem_req_ready = 1'b0; c_valid[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1; mem_resp_data = rnd_data();
      #1;
      chk("mid_beat_route", rsp_v, 2'b10);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("in_reset_resp", rsp_v, 0);
    chk("in_reset_req_valid", mem_req_valid, 0);
    tick();
    reset = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("post_reset_resp", rsp_v, 0);
    chk("post_reset_req_valid", mem_req_valid, 0);
    chk("post_reset_spurious", spurious_resp, 0);
    tick();
    setup_req(1'b0, 1'b0, AW'(28'h0000040));
    serve(1'b0, 1, 0, 1'b1);
    last_model = 1'b0;

    // randomized traffic against the arbitration model
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 2);
      a = AW'($urandom);
      if (mode != 1) setup_req(1'b0, 1'($urandom), a);
      if (mode != 0) setup_req(1'b1, 1'($urandom), a ^ AW'(3));
      if (mode == 0)      w = 1'b0;
      else if (mode == 1) w = 1'b1;
      else                w = last_model ? 1'b0 : 1'b1;
      serve(w, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      last_model = w;
      if (mode == 2) begin
        serve(!w, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        last_model = !w;
      end
    end
    #1;
    chk("rand_idle", mem_req_valid, 0);
    chk("rand_no_spurious", spurious_resp, 0);
    tick();

    // fixed priority: after D was served last, a tie still goes to D
    for (int r = 0; r < 2; r++) begin
      reset = 1'b1; clear_caches(); tick(); reset = 1'b0;
      setup_req(1'b1, 1'b0, AW'($urandom));
      serve(1'b1, 0, 0, 1'b0);
      a = AW'($urandom);
      setup_req(1'b0, 1'b0, a);
      setup_req(1'b1, 1'b0, a ^ AW'(5));
      tick();
      #1;
      chk("rr_tie_after_d", mem_req_addr, c_addr[0]);
      chk("fp_req_valid", fp_mem_req_valid, 1);
      chk("fp_tie_addr", fp_mem_req_addr, c_addr[1]);
      chk("fp_rw", fp_mem_req_rw, 0);
      chk("fp_data_valid", fp_mem_req_data_valid, 0);
      chk("fp_data_bits", fp_mem_req_data_bits, c_data[1]);
      chk("fp_data_mask", fp_mem_req_data_mask, c_mask[1]);
      chk("fp_readies", {fp_d_req_ready, fp_i_req_ready, fp_d_data_ready, fp_i_data_ready}, 0);
      chk("fp_resp", {fp_d_resp_valid, fp_i_resp_valid}, 0);
      chk("fp_i_resp_data", fp_i_resp_data, mem_resp_data);
      chk("fp_d_resp_data", fp_d_resp_data, mem_resp_data);
      chk("fp_spurious", fp_spurious, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
